// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter sharing one mem_controller port among NUM_REQ requesters.
// Define MEM_ARB_LOCK_EN to let req_lock hold the grant for up to LOCK_MAX consecutive grants.
`ifndef MEM_ADDR_WIDTH
`define MEM_ADDR_WIDTH 32
`endif
`ifndef MEM_DATA_WIDTH
`define MEM_DATA_WIDTH 32
`endif

module mem_port_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int ADDR_W   = `MEM_ADDR_WIDTH,
    parameter int DATA_W   = `MEM_DATA_WIDTH,
    parameter int LOCK_MAX = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ-1:0]    req_we,
    input  logic [NUM_REQ-1:0]    req_lock,
    input  logic [2*NUM_REQ-1:0]  req_dw,
    input  logic [ADDR_W*NUM_REQ-1:0] req_addr,
    input  logic [DATA_W*NUM_REQ-1:0] req_wdata,
    output logic [NUM_REQ-1:0]    gnt,
    output logic [NUM_REQ-1:0]    rd_valid,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  mem_we,
    output logic [1:0]            mem_dw,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_in,
    input  logic [DATA_W-1:0]     mem_out
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(LOCK_MAX) + 1;

    logic [IDX_W-1:0]   last_q, last_d, sel, g;
    logic [NUM_REQ-1:0] rd_valid_q, rd_valid_d;
    logic               any, gv, force_lock;

    // First requester found searching from last+1; reverse loop so the nearest index wins.
    always_comb begin
        any = 1'b0;
        sel = last_q;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (req[(int'(last_q) + k) % NUM_REQ]) begin
                sel = IDX_W'((int'(last_q) + k) % NUM_REQ);
                any = 1'b1;
            end
        end
    end

    assign g  = force_lock ? last_q : sel;
    assign gv = rst_n && (force_lock || any);

    always_comb begin
        gnt        = gv ? (NUM_REQ'(1) << g) : '0;
        mem_we     = gv && req_we[g];
        mem_dw     = gv ? req_dw[2*g +: 2] : '0;
        mem_addr   = gv ? req_addr[ADDR_W*g +: ADDR_W] : '0;
        mem_in     = gv ? req_wdata[DATA_W*g +: DATA_W] : '0;
        last_d     = gv ? g : last_q;
        rd_valid_d = (gv && !req_we[g]) ? gnt : '0;
    end

    assign rd_valid = rd_valid_q;
    assign rd_data  = (|rd_valid_q) ? mem_out : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q     <= IDX_W'(NUM_REQ - 1);
            rd_valid_q <= '0;
        end else begin
            last_q     <= last_d;
            rd_valid_q <= rd_valid_d;
        end
    end

`ifdef MEM_ARB_LOCK_EN
    logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
    logic             lock_vld_q, lock_vld_d;

    // lock_cnt includes the grant that first took the lock, so LOCK_MAX bounds the whole run.
    assign force_lock = lock_vld_q && req[last_q] && (lock_cnt_q < CNT_W'(LOCK_MAX));

    always_comb begin
        lock_vld_d = gv && req_lock[g];
        lock_cnt_d = !lock_vld_d ? '0 : force_lock ? lock_cnt_q + 1'b1 : CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_cnt_q <= '0;
            lock_vld_q <= 1'b0;
        end else begin
            lock_cnt_q <= lock_cnt_d;
            lock_vld_q <= lock_vld_d;
        end
    end
`else
    logic unused_lock;
    assign unused_lock = ^req_lock;
    assign force_lock  = 1'b0;
`endif
endmodule
